// File: rtl/pwm_ramp_pkg.sv
// Shared widths and state encoding for the soft-start PWM generator.
package pwm_ramp_pkg;

  localparam int PWM_W = 12;
  localparam logic [PWM_W-1:0] PWM_MAX = 12'd4095;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_ramp_timebase.sv
// Prescaler plus 12-bit period counter; one PWM period is 4096 prescaled ticks.
module pwm_timebase
  import pwm_ramp_pkg::*;
#(
  parameter int PRESCALE = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic             tick,
  output logic [PWM_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [PWM_W-1:0] PreLast = PWM_W'(PRESCALE - 1);

  logic [PWM_W-1:0] pre_q, pre_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;

  assign tick = (pre_q == PreLast);
  assign wrap = tick && (cnt_q == PWM_MAX);
  assign cnt  = cnt_q;

  // The period counter relies on natural 12-bit overflow for its 4095 -> 0 wrap.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_ramp.sv
// Soft-start PWM: ramps the applied duty up by STEP per period, applies decreases
// at the next period boundary, and forces the output low as soon as enable drops.
module pwm_ramp
  import pwm_ramp_pkg::*;
#(
  parameter int PRESCALE = 25,
  parameter int STEP     = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [PWM_W-1:0] duty,
  output logic             pulse,
  output logic             period_start,
  output logic [PWM_W-1:0] duty_active,
  output logic             ramping
);

  state_e           state_q, state_d;
  logic [PWM_W-1:0] active_q, active_d;
  logic             pulse_q, periodStart_q, ramping_q;
  logic [PWM_W:0]   sum;
  logic             clr;
  logic [PWM_W-1:0] cnt;
  logic             wrap;
  logic             tickUnused;

  // Counters sit at zero in IDLE and clear on the same edge that enable is seen low.
  assign clr = (state_q == IDLE) || !enable;

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tickUnused),
    .cnt (cnt),
    .wrap(wrap)
  );

  // Duty is only sampled on wrap, so a period never changes width part-way through.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    sum      = {1'b0, active_q} + (PWM_W + 1)'(STEP);
    if (!enable) begin
      state_d  = IDLE;
      active_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = RAMP;
          active_d = '0;
        end
        RAMP: begin
          if (wrap) begin
            if ((duty <= active_q) || (sum >= {1'b0, duty})) begin
              active_d = duty;
              state_d  = HOLD;
            end else begin
              active_d = sum[PWM_W-1:0];
            end
          end
        end
        HOLD: begin
          if (wrap) begin
            if (duty > active_q) begin
              state_d = RAMP;
            end else if (duty < active_q) begin
              active_d = duty;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          active_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      active_q      <= '0;
      pulse_q       <= 1'b0;
      periodStart_q <= 1'b0;
      ramping_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      pulse_q       <= (state_q != IDLE) && enable && (cnt < active_q);
      periodStart_q <= wrap && enable && (state_q != IDLE);
      ramping_q     <= (state_d == RAMP);
    end
  end

  assign pulse        = pulse_q;
  assign period_start = periodStart_q;
  assign duty_active  = active_q;
  assign ramping      = ramping_q;

endmodule

// File: doc/pwm_ramp.md
# pwm_ramp

Soft-start PWM generator that produces the `pulse` drive signal consumed by the switch/H-bridge enable stage. It takes the 12-bit switch-selected duty request and generates a fixed-frequency PWM waveform. It ramps the applied duty up by a fixed step per PWM period so motor inrush stays bounded. Duty decreases apply at the next period boundary without ramping, and the output drops to zero one cycle after `enable` is removed.

## Interface
- `PRESCALE`, 25: clk cycles per PWM count tick. Legal range is 1..4096.
- `STEP`, 256: duty increment per PWM period while ramping up. Legal range is 1..4095.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst` input 1: reset; one clock, synchronous, active-high.
- `enable` input 1: run request; low forces IDLE.
- `duty` input 12: target duty, 0..4095; sampled only at period boundaries.
- `pulse` output 1: registered PWM output; feeds the EN logic.
- `period_start` output 1: one-cycle strobe at each PWM period wrap.
- `duty_active` output 12: duty currently being applied.
- `ramping` output 1: high while state is RAMP.

## Operation
- Prescaler `pre` (12-bit) counts 0..PRESCALE-1.
  - `tick` = (`pre` == PRESCALE-1).
  - `pre` wraps to 0 on `tick`.
- Period counter `cnt` (12-bit) increments on `tick` and wraps 4095→0. One PWM period is therefore 4096 ticks.
- `wrap` = `tick` && (`cnt` == 4095).
- Three states, encoded in 2 bits:
  - **IDLE**
    - `pre`, `cnt`, `duty_active` and `pulse` are held at 0.
    - When `enable`=1, the next state is RAMP.
  - **RAMP**
    - On `wrap`, compute `sum` = {1'b0,`duty_active`} + STEP as a 13-bit value.
    - If `duty` <= `duty_active`, load `duty_active` := `duty` and go to HOLD.
    - Otherwise, if `sum` >= `duty`, load `duty_active` := `duty` and go to HOLD.
    - Otherwise, load `duty_active` := `sum`[11:0] and stay in RAMP.
  - **HOLD**
    - On `wrap`, if `duty` > `duty_active`, go to RAMP; `duty_active` is unchanged on this edge.
    - If `duty` < `duty_active`, load `duty_active` := `duty` and stay in HOLD.
    - If they are equal, nothing changes.
  - **Any state**: `enable`=0 forces IDLE on the next edge and clears all counters and `duty_active`. This takes priority over `wrap`.
- `pulse` register:
  - In a non-IDLE state with `enable`=1, `pulse` <= (`cnt` < `duty_active`); otherwise `pulse` <= 0.
  - `duty_active`=0 gives a constant low. `duty_active`=4095 gives 4095/4096 high.
- `period_start` is a register loaded with `wrap` && `enable` && (state != IDLE).
- `ramping` is a register loaded with (next state == RAMP).
- The first period after leaving IDLE runs at `duty_active`=0, so `pulse` stays low until the first wrap.

## Timing
- Reset values: state=IDLE; `pre`=0, `cnt`=0, `duty_active`=0; `pulse`=0, `period_start`=0, `ramping`=0.
- Reset mid-operation behaves exactly like power-up: all outputs read 0 on the edge following `rst`=1. `rst` has priority over `enable`.
- `pulse` latency is 1 clk after `cnt`/`duty_active`. `pulse` changes only on `tick` edges or on IDLE entry.
- Enable removal: `pulse`=0 on the first edge after `enable` is sampled low.
- `duty` changes mid-period are ignored until the next `wrap`. No glitches occur within a period.
- `period_start` and the `duty_active` update occur on the same edge. The new `duty_active` governs `cnt`=0 of the new period.
- `duty` is sampled only at `wrap`. If `duty` changes at the same edge as `wrap`, the value present at that edge is used.
- Ramp length from 0 to target T is ceil(T/STEP) periods.

## Structure
- A shared package holds:
  - `PWM_W` = 12 and `PWM_MAX` = 12'd4095.
  - The state typedef {IDLE, RAMP, HOLD}.
- The prescaler and period counter form one natural sub-module, `pwm_timebase`, with ports `clk`, `rst`, `clr`, `tick`, `cnt`, `wrap`.
- The state machine, ramp arithmetic and output compare stay in `pwm_ramp`.

## Test plan
- **Reset:** PRESCALE=2, STEP=1024; hold `rst` for 3 cycles with `enable`=1 → all outputs 0 and state IDLE throughout.
- **Full ramp:** `enable`=1, `duty`=4095.
  - `duty_active` must step 0→1024→2048→3072→4095 on successive `wrap`s.
  - `ramping` is high for the first four periods, then low.
  - High time is 4095 of 4096 ticks in the final period.
- **Decrease:** in HOLD at 3072, set `duty`=128 mid-period.
  - `pulse` width is unchanged until the next `period_start`.
  - Then `duty_active`=128 with no ramp, and high time is 128 ticks.
- **Enable drop:** deassert `enable` at `cnt`=500 while `pulse`=1 → `pulse`=0 next edge, `cnt`=0, `duty_active`=0. Re-enable → restarts at 0.
- **Zero duty:** `duty`=0 for 3 periods → `pulse` never high, state reaches HOLD, `period_start` fires every 8192 clk (PRESCALE=2).
- **Reset mid-ramp:** pulse `rst` while `duty_active`=2048 in RAMP → outputs 0 next edge. With `enable` still high, the ramp restarts from 0.
